// File: rtl/exp_sequencer.sv
// Exponent micro-sequencer: drives the exponent register file through LOAD/STEP1/STEP2 micro-ops.
// Optional range flag is compiled in with EXP_SEQ_RANGE_EN.
module exp_sequencer #(
  parameter int REGISTER_WIDTH = 9
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  input  logic                      start_in,
  input  logic [1:0]                op_in,
  input  logic [7:0]                expA_in,
  input  logic [7:0]                expB_in,
  output logic                      ready_out,
  output logic                      done_out,
  output logic [REGISTER_WIDTH-1:0] result_out,
  output logic                      borrow_out,
  output logic                      range_err_out,
  output logic                      writeEnableR0_out,
  output logic                      writeEnableR1_out,
  output logic [REGISTER_WIDTH-1:0] writeValueR0_out,
  output logic [REGISTER_WIDTH-1:0] writeValueR1_out,
  output logic [2:0]                readSelectA_out,
  output logic [2:0]                readSelectB_out,
  input  logic [REGISTER_WIDTH-1:0] readResultA_in,
  input  logic [REGISTER_WIDTH-1:0] readResultB_in
);
  localparam int W = REGISTER_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD, STEP1, STEP2, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIV = 2'b01, OP_I2F = 2'b10, OP_ALN = 2'b11} op_t;

  localparam logic [2:0] SEL_R0 = 3'b000, SEL_R1 = 3'b001, SEL_ZERO = 3'b010,
                         SEL_158 = 3'b101, SEL_127 = 3'b110;

  state_t       state, state_nx;
  op_t          op_q;
  logic [7:0]   a_q, b_q;
  logic         alu_sub, final_step;
  logic [W:0]   alu_sum;
  logic [W-1:0] alu_res;
  logic         alu_borrow;

  // Shared adder: subtract is A + ~B + 1, borrow is the missing carry-out.
  assign alu_sum    = {1'b0, readResultA_in} + {1'b0, readResultB_in ^ {W{alu_sub}}} + (W+1)'(alu_sub);
  assign alu_res    = alu_sum[W-1:0];
  assign alu_borrow = alu_sub & ~alu_sum[W];

  always_comb begin
    state_nx          = state;
    ready_out         = 1'b0;
    done_out          = 1'b0;
    writeEnableR0_out = 1'b0;
    writeEnableR1_out = 1'b0;
    writeValueR0_out  = W'(a_q);
    writeValueR1_out  = W'(b_q);
    readSelectA_out   = SEL_ZERO;
    readSelectB_out   = SEL_ZERO;
    alu_sub           = 1'b0;
    final_step        = 1'b0;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (start_in) state_nx = LOAD;
      end
      LOAD: begin
        writeEnableR0_out = 1'b1;
        writeEnableR1_out = 1'b1;
        state_nx          = STEP1;
      end
      STEP1: begin
        writeEnableR0_out = 1'b1;
        writeValueR0_out  = alu_res;
        case (op_q)
          OP_MUL: begin readSelectA_out = SEL_R0;  readSelectB_out = SEL_R1;  end
          OP_DIV: begin readSelectA_out = SEL_R0;  readSelectB_out = SEL_127; end
          OP_I2F: begin readSelectA_out = SEL_158; readSelectB_out = SEL_R1; alu_sub = 1'b1; end
          default: begin readSelectA_out = SEL_R0; readSelectB_out = SEL_R1; alu_sub = 1'b1; end
        endcase
        if (op_q == OP_MUL || op_q == OP_DIV) state_nx = STEP2;
        else begin
          final_step = 1'b1;
          state_nx   = DONE;
        end
      end
      STEP2: begin
        writeEnableR0_out = 1'b1;
        writeValueR0_out  = alu_res;
        readSelectA_out   = SEL_R0;
        readSelectB_out   = (op_q == OP_MUL) ? SEL_127 : SEL_R1;
        alu_sub           = 1'b1;
        final_step        = 1'b1;
        state_nx          = DONE;
      end
      DONE: begin
        done_out = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state      <= IDLE;
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      result_out <= '0;
      borrow_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start_in) begin
        op_q <= op_t'(op_in);
        a_q  <= expA_in;
        b_q  <= expB_in;
      end
      if (final_step) begin
        result_out <= alu_res;
        borrow_out <= alu_borrow;
      end
    end
  end

`ifdef EXP_SEQ_RANGE_EN
  // Only MUL/DIV produce a new FP exponent; INT2FP/ALIGN never flag.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) range_err_out <= 1'b0;
    else if (final_step)
      range_err_out <= (op_q == OP_MUL || op_q == OP_DIV) &&
                       (alu_borrow || alu_res == '0 || alu_res > W'(254));
  end
`else
  assign range_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_exp_sequencer.sv
// Directed bench for exp_sequencer with a behavioural register file attached.
module tb_exp_sequencer;
  localparam int W = 9;

  logic         clk_in = 1'b0;
  logic         reset_n_in;
  logic         start_in;
  logic [1:0]   op_in;
  logic [7:0]   expA_in, expB_in;
  logic         ready_out, done_out, borrow_out, range_err_out;
  logic [W-1:0] result_out;
  logic         we0, we1;
  logic [W-1:0] wv0, wv1;
  logic [2:0]   sel_a, sel_b;
  logic [W-1:0] rd_a, rd_b;

  int n_cmp = 0;
  int n_err = 0;

`ifdef EXP_SEQ_RANGE_EN
  localparam bit RNG = 1'b1;
`else
  localparam bit RNG = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  exp_sequencer #(.REGISTER_WIDTH(W)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .start_in(start_in), .op_in(op_in),
    .expA_in(expA_in), .expB_in(expB_in), .ready_out(ready_out), .done_out(done_out),
    .result_out(result_out), .borrow_out(borrow_out), .range_err_out(range_err_out),
    .writeEnableR0_out(we0), .writeEnableR1_out(we1),
    .writeValueR0_out(wv0), .writeValueR1_out(wv1),
    .readSelectA_out(sel_a), .readSelectB_out(sel_b),
    .readResultA_in(rd_a), .readResultB_in(rd_b)
  );

  // Register file model: two GPRs plus constant selects.
  logic [W-1:0] r0 = '0, r1 = '0;
  always @(posedge clk_in) begin
    if (we0) r0 <= wv0;
    if (we1) r1 <= wv1;
  end
  function automatic logic [W-1:0] rf_rd(input logic [2:0] s);
    case (s)
      3'd0: rf_rd = r0;
      3'd1: rf_rd = r1;
      3'd2: rf_rd = 9'd0;
      3'd3: rf_rd = 9'd1;
      3'd4: rf_rd = 9'd31;
      3'd5: rf_rd = 9'd158;
      3'd6: rf_rd = 9'd127;
      default: rf_rd = 9'd511;
    endcase
  endfunction
  assign rd_a = rf_rd(sel_a);
  assign rd_b = rf_rd(sel_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE and follow it to done; latency counts cycles after the accept edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [8:0] exp_res, input logic exp_bor,
                        input logic exp_rng);
    int n;
    @(negedge clk_in);
    check({tag, "_ready"}, ready_out, 1'b1);
    check({tag, "_idle_done"}, done_out, 1'b0);
    start_in = 1'b1; op_in = op; expA_in = a; expB_in = b;
    @(negedge clk_in);
    start_in = 1'b0;
    n = 1;
    while (!done_out && n < 10) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, result_out, exp_res);
    check({tag, "_borrow"}, borrow_out, exp_bor);
    check({tag, "_range"}, range_err_out, exp_rng);
  endtask

  initial begin
    int done_seen;
    reset_n_in = 1'b0; start_in = 1'b0; op_in = 2'b00; expA_in = '0; expB_in = '0;
    #1;
    check("rst_ready", ready_out, 1'b1);
    check("rst_done", done_out, 1'b0);
    check("rst_result", result_out, 0);
    check("rst_we", {we0, we1}, 2'b00);
    check("rst_sel", {sel_a, sel_b}, 6'b010_010);
    check("rst_flags", {borrow_out, range_err_out}, 2'b00);
    @(negedge clk_in); @(negedge clk_in);
    reset_n_in = 1'b1;

    run_op("mul1", 2'b00, 8'd130, 8'd140, 4, 9'd143, 1'b0, 1'b0);
    run_op("mul2", 2'b00, 8'd50,  8'd60,  4, 9'd495, 1'b1, RNG);
    run_op("div1", 2'b01, 8'd200, 8'd100, 4, 9'd227, 1'b0, 1'b0);
    run_op("div2", 2'b01, 8'd1,   8'd200, 4, 9'd440, 1'b1, RNG);
    run_op("i2f",  2'b10, 8'd0,   8'd5,   3, 9'd153, 1'b0, 1'b0);
    run_op("aln",  2'b11, 8'd10,  8'd20,  3, 9'd502, 1'b1, 1'b0);
    run_op("mulz", 2'b00, 8'd127, 8'd0,   4, 9'd0,   1'b0, RNG);

    // Write-port trace of a MUL with start held and a different op presented meanwhile.
    @(negedge clk_in);
    start_in = 1'b1; op_in = 2'b00; expA_in = 8'd130; expB_in = 8'd140;
    @(negedge clk_in);
    check("tr_load_we", {we0, we1}, 2'b11);
    check("tr_load_wv", {wv0, wv1}, {9'd130, 9'd140});
    op_in = 2'b11; expA_in = 8'd5; expB_in = 8'd9;
    @(negedge clk_in);
    check("tr_s1_we", {we0, we1}, 2'b10);
    check("tr_s1_wv", wv0, 9'd270);
    check("tr_s1_sel", {sel_a, sel_b}, 6'b000_001);
    check("tr_s1_ready", ready_out, 1'b0);
    @(negedge clk_in);
    check("tr_s2_we", {we0, we1}, 2'b10);
    check("tr_s2_wv", wv0, 9'd143);
    check("tr_s2_sel", {sel_a, sel_b}, 6'b000_110);
    @(negedge clk_in);
    check("tr_done", done_out, 1'b1);
    check("tr_done_we", {we0, we1}, 2'b00);
    check("tr_result", result_out, 9'd143);
    start_in = 1'b0;
    @(negedge clk_in);
    check("tr_after_done", done_out, 1'b0);

    // INT2FP STEP1 selects.
    start_in = 1'b1; op_in = 2'b10; expB_in = 8'd32;
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    check("i2f_s1_sel", {sel_a, sel_b}, 6'b101_001);
    check("i2f_s1_wv", wv0, 9'd126);
    @(negedge clk_in);
    check("i2f32_result", result_out, 9'd126);

    // Abort a MUL in STEP1 with an asynchronous reset.
    run_op("pre_abort", 2'b00, 8'd50, 8'd60, 4, 9'd495, 1'b1, RNG);
    @(negedge clk_in);
    start_in = 1'b1; op_in = 2'b00; expA_in = 8'd130; expB_in = 8'd140;
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    #2 reset_n_in = 1'b0;
    #1;
    check("abort_ready", ready_out, 1'b1);
    check("abort_result", result_out, 0);
    check("abort_flags", {borrow_out, range_err_out}, 2'b00);
    check("abort_we", {we0, we1}, 2'b00);
    check("abort_sel", {sel_a, sel_b}, 6'b010_010);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (done_out) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_op("post_abort", 2'b11, 8'd200, 8'd20, 3, 9'd180, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/exp_sequencer.md
# exp_sequencer

Exponent micro-sequencer: the master side of the 9-bit exponent register file (two GPRs R0/R1 plus six constant selects). Accepts one exponent operation per request (FP multiply, FP divide, int-to-float, add-alignment difference), drives the register file's write and read-select ports through a fixed micro-op sequence using an internal 9-bit adder/subtractor, and returns a registered result with borrow/range flags. Sits between the FPU control unit and the exponent register file.

## Interface
- REGISTER_WIDTH, 9, exponent datapath width; must match the register file.
- clk_in  input  1  clock; all state updates on rising edge.
- reset_n_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  request valid; accepted when start_in && ready_out.
- op_in  input  2  00 MUL, 01 DIV, 10 INT2FP, 11 ALIGN; sampled on acceptance.
- expA_in  input  8  operand A (biased exponent); sampled on acceptance.
- expB_in  input  8  operand B (biased exponent, or leading-zero count 0..32 for INT2FP).
- ready_out  output  1  high in IDLE only (combinational from state).
- done_out  output  1  one-cycle pulse, result/flags valid.
- result_out  output  9  registered result, held until next done.
- borrow_out  output  1  final subtract borrowed (result is negative mod 512).
- range_err_out  output  1  result outside normal exponent range (see Configuration).
- writeEnableR0_out, writeEnableR1_out  output  1 each  register file write enables.
- writeValueR0_out, writeValueR1_out  output  9 each  register file write data.
- readSelectA_out, readSelectB_out  output  3 each  000 R0, 001 R1, 010 zero, 011 one, 100 31, 101 158, 110 127, 111 511.
- readResultA_in, readResultB_in  input  9 each  combinational register file read data.

## Operation
- FSM states: IDLE, LOAD, STEP1, STEP2, DONE; one cycle each.
- IDLE: ready_out=1; write enables 0; both selects 010. On accept: latch op, A, B; -> LOAD. start_in outside IDLE is ignored.
- LOAD: WE R0=WE R1=1, R0<={0,A}, R1<={0,B}; -> STEP1.
- ALU: add = A+B (9-bit, carry discarded; cannot overflow for legal sequences); sub = A+~B+1, borrow = ~carry-out. Operands are readResultA_in/readResultB_in; result written to R0 (WE R0=1, R1 untouched).
- STEP1: MUL R0+R1; DIV R0+127 (selB=110); INT2FP 158-R1 (selA=101, selB=001, sub); ALIGN R0-R1 (sub). MUL/DIV -> STEP2; INT2FP/ALIGN are final -> DONE.
- STEP2 (final): MUL R0-127 (selB=110); DIV R0-R1. -> DONE.
- Final step also registers ALU result into result_out, borrow into borrow_out, range check into range_err_out.
- DONE: done_out=1, no writes; -> IDLE.
- Arithmetic: MUL = A+B-127, DIV = A+127-B (ordered so only the final subtract can borrow), INT2FP = 158-lzc, ALIGN = A-B; negative results wrap mod 512 with borrow_out=1.

## Timing
- Reset (async assert, any state): state IDLE, result_out=0, borrow_out=0, range_err_out=0, done_out=0, write enables 0, selects 010, ready_out=1. Release synchronous to clk_in; first accept possible on the first edge after release.
- Latency from accepting edge to done_out high: MUL/DIV 4 cycles, INT2FP/ALIGN 3 cycles. Throughput: next accept one cycle after done (IDLE).
- Reset mid-operation aborts; no done_out; register file contents undefined for the aborted op.
- result_out/flags change only on the final-step edge.

## Configuration
- EXP_SEQ_RANGE_EN defined: range_err_out = borrow || result==0 || result>254, evaluated for MUL and DIV only; 0 for INT2FP/ALIGN.
- Not defined: range check logic absent, range_err_out tied to 0.

## Test plan
- Reset asserted mid-STEP1 of MUL -> immediately IDLE, ready_out=1, result_out=0, no done_out pulse.
- MUL A=130,B=140 -> done after 4 cycles, result_out=143, borrow_out=0, range_err_out=0.
- MUL A=50,B=60 -> result_out=495, borrow_out=1, range_err_out=1 (0 without EXP_SEQ_RANGE_EN).
- DIV A=200,B=100 -> result_out=227; DIV A=1,B=200 -> result_out=440, borrow_out=1.
- INT2FP B=5 -> done after 3 cycles, result_out=153; ALIGN A=10,B=20 -> result_out=502, borrow_out=1.
- start_in held high with new op during STEP1 -> ignored; write-port trace matches LOAD/STEP sequence exactly; back-to-back ops accepted one cycle after each done_out.
